// File: rtl/pawn_eval_sequencer.sv
// Sequences one board request through the pawn evaluator and tapers mg/eg by phase into one score.
// Result valid 3 cycles after eval_valid; one request in flight, req_ready low until the score is taken.
`ifndef BOARD_WIDTH
`define BOARD_WIDTH 128
`endif

module pawn_eval_sequencer #(
  parameter int EVAL_WIDTH  = 24,
  parameter int PHASE_SHIFT = 5,
  parameter int TIMEOUT     = 64
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [`BOARD_WIDTH-1:0]      req_board,
  input  logic                         req_white_to_move,
  input  logic [PHASE_SHIFT:0]         req_phase,
  output logic                         board_valid,
  output logic [`BOARD_WIDTH-1:0]      board,
  output logic                         white_to_move,
  output logic                         clear_eval,
  input  logic signed [EVAL_WIDTH-1:0] eval_mg,
  input  logic signed [EVAL_WIDTH-1:0] eval_eg,
  input  logic                         eval_valid,
  output logic                         result_valid,
  input  logic                         result_ready,
  output logic signed [EVAL_WIDTH-1:0] result_score,
  output logic                         result_error
);

  localparam int PW = EVAL_WIDTH + PHASE_SHIFT + 2;
  localparam int TW = $clog2(TIMEOUT) + 1;
  localparam logic [PHASE_SHIFT:0] PH_FULL    = {1'b1, {PHASE_SHIFT{1'b0}}};
  localparam logic [TW-1:0]        TIMER_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    ST_FLUSH,
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_MULT,
    ST_SUM,
    ST_DONE
  } state_e;

  state_e                    state_q, state_d;
  logic                      req_ready_q, req_ready_d;
  logic                      board_valid_q, board_valid_d;
  logic [`BOARD_WIDTH-1:0]   board_q, board_d;
  logic                      wtm_q, wtm_d;
  logic                      clear_eval_q, clear_eval_d;
  logic                      result_valid_q, result_valid_d;
  logic                      result_error_q, result_error_d;
  logic signed [EVAL_WIDTH-1:0] score_q, score_d;
  logic [PHASE_SHIFT:0]      phase_q, phase_d;
  logic signed [EVAL_WIDTH-1:0] mg_q, mg_d;
  logic signed [EVAL_WIDTH-1:0] eg_q, eg_d;
  logic signed [PW-1:0]      pm_q, pm_d;
  logic signed [PW-1:0]      pe_q, pe_d;
  logic [TW-1:0]             timer_q, timer_d;

  logic signed [PW-1:0]      mg_ext, eg_ext, ph_ext, cph_ext, sum;
  logic [PHASE_SHIFT:0]      cphase;
  logic                      unused_sum_bits;

  // Operands widened so the signed multiply sees a non-negative phase weight.
  assign cphase  = PH_FULL - phase_q;
  assign mg_ext  = {{(PW-EVAL_WIDTH){mg_q[EVAL_WIDTH-1]}}, mg_q};
  assign eg_ext  = {{(PW-EVAL_WIDTH){eg_q[EVAL_WIDTH-1]}}, eg_q};
  assign ph_ext  = {{(PW-PHASE_SHIFT-1){1'b0}}, phase_q};
  assign cph_ext = {{(PW-PHASE_SHIFT-1){1'b0}}, cphase};
  assign sum     = pm_q + pe_q;
  assign unused_sum_bits = ^{sum[PW-1:PHASE_SHIFT+EVAL_WIDTH], sum[PHASE_SHIFT-1:0]};

  always_comb begin
    state_d        = state_q;
    req_ready_d    = req_ready_q;
    board_valid_d  = board_valid_q;
    board_d        = board_q;
    wtm_d          = wtm_q;
    clear_eval_d   = 1'b0;
    result_valid_d = result_valid_q;
    result_error_d = result_error_q;
    score_d        = score_q;
    phase_d        = phase_q;
    mg_d           = mg_q;
    eg_d           = eg_q;
    pm_d           = pm_q;
    pe_d           = pe_q;
    timer_d        = timer_q;

    case (state_q)
      ST_FLUSH: begin
        clear_eval_d = 1'b1;
        state_d      = ST_IDLE;
      end
      ST_IDLE: begin
        req_ready_d   = 1'b1;
        board_valid_d = 1'b0;
        if (req_valid && req_ready_q) begin
          req_ready_d = 1'b0;
          board_d     = req_board;
          wtm_d       = req_white_to_move;
          phase_d     = (req_phase > PH_FULL) ? PH_FULL : req_phase;
          state_d     = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        board_valid_d = 1'b1;
        timer_d       = '0;
        state_d       = ST_WAIT;
      end
      ST_WAIT: begin
        timer_d = timer_q + TW'(1);
        if (eval_valid) begin
          mg_d          = eval_mg;
          eg_d          = eval_eg;
          clear_eval_d  = 1'b1;
          board_valid_d = 1'b0;
          state_d       = ST_MULT;
        end else if (timer_q == TIMER_LAST) begin
          clear_eval_d   = 1'b1;
          board_valid_d  = 1'b0;
          score_d        = '0;
          result_error_d = 1'b1;
          result_valid_d = 1'b1;
          state_d        = ST_DONE;
        end
      end
      ST_MULT: begin
        pm_d    = mg_ext * ph_ext;
        pe_d    = eg_ext * cph_ext;
        state_d = ST_SUM;
      end
      ST_SUM: begin
        // Slicing above the fraction bits is an arithmetic shift, i.e. floor.
        score_d        = sum[PHASE_SHIFT +: EVAL_WIDTH];
        result_error_d = 1'b0;
        result_valid_d = 1'b1;
        state_d        = ST_DONE;
      end
      ST_DONE: begin
        if (result_ready) begin
          result_valid_d = 1'b0;
          result_error_d = 1'b0;
          req_ready_d    = 1'b1;
          state_d        = ST_IDLE;
        end
      end
      default: state_d = ST_FLUSH;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= ST_FLUSH;
      req_ready_q    <= 1'b0;
      board_valid_q  <= 1'b0;
      board_q        <= '0;
      wtm_q          <= 1'b0;
      clear_eval_q   <= 1'b0;
      result_valid_q <= 1'b0;
      result_error_q <= 1'b0;
      score_q        <= '0;
      phase_q        <= '0;
      mg_q           <= '0;
      eg_q           <= '0;
      pm_q           <= '0;
      pe_q           <= '0;
      timer_q        <= '0;
    end else begin
      state_q        <= state_d;
      req_ready_q    <= req_ready_d;
      board_valid_q  <= board_valid_d;
      board_q        <= board_d;
      wtm_q          <= wtm_d;
      clear_eval_q   <= clear_eval_d;
      result_valid_q <= result_valid_d;
      result_error_q <= result_error_d;
      score_q        <= score_d;
      phase_q        <= phase_d;
      mg_q           <= mg_d;
      eg_q           <= eg_d;
      pm_q           <= pm_d;
      pe_q           <= pe_d;
      timer_q        <= timer_d;
    end
  end

  assign req_ready     = req_ready_q;
  assign board_valid   = board_valid_q;
  assign board         = board_q;
  assign white_to_move = wtm_q;
  assign clear_eval    = clear_eval_q;
  assign result_valid  = result_valid_q;
  assign result_error  = result_error_q;
  assign result_score  = score_q;

`ifndef SYNTHESIS
  a_clear_one_cycle: assert property (@(posedge clk) disable iff (!reset_n)
    clear_eval_q |=> !clear_eval_q);
  a_phase_legal: assert property (@(posedge clk) disable iff (!reset_n)
    phase_q <= PH_FULL);
`endif

endmodule

// File: tb/tb_pawn_eval_sequencer.sv
// Directed bench for pawn_eval_sequencer with a behavioural pawn evaluator of programmable latency.
`ifndef BOARD_WIDTH
`define BOARD_WIDTH 128
`endif

module tb_pawn_eval_sequencer;

  localparam int EW = 24;
  localparam int PS = 5;
  localparam int BW = `BOARD_WIDTH;

  logic                 clk = 1'b0;
  logic                 reset_n;
  logic                 req_valid;
  logic                 req_ready;
  logic [BW-1:0]        req_board;
  logic                 req_white_to_move;
  logic [PS:0]          req_phase;
  logic                 board_valid;
  logic [BW-1:0]        board;
  logic                 white_to_move;
  logic                 clear_eval;
  logic signed [EW-1:0] eval_mg;
  logic signed [EW-1:0] eval_eg;
  logic                 eval_valid;
  logic                 result_valid;
  logic                 result_ready;
  logic signed [EW-1:0] result_score;
  logic                 result_error;

  always #5 clk = ~clk;

  pawn_eval_sequencer #(.EVAL_WIDTH(EW), .PHASE_SHIFT(PS), .TIMEOUT(64)) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .req_valid         (req_valid),
    .req_ready         (req_ready),
    .req_board         (req_board),
    .req_white_to_move (req_white_to_move),
    .req_phase         (req_phase),
    .board_valid       (board_valid),
    .board             (board),
    .white_to_move     (white_to_move),
    .clear_eval        (clear_eval),
    .eval_mg           (eval_mg),
    .eval_eg           (eval_eg),
    .eval_valid        (eval_valid),
    .result_valid      (result_valid),
    .result_ready      (result_ready),
    .result_score      (result_score),
    .result_error      (result_error)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, $signed(got), $signed(exp));
    end
  endtask

  // Evaluator model: answers ev_lat cycles after a board_valid rising edge, holds until cleared.
  logic                 ev_never = 1'b0;
  int                   ev_lat   = 7;
  logic signed [EW-1:0] ev_mg, ev_eg;
  logic                 busy = 1'b0, bv_prev = 1'b0;
  int                   cnt = 0, n_rise = 0, n_clr = 0, low_run = 999, last_low_run = 0;

  always @(negedge clk) begin
    if (!reset_n) begin
      eval_valid = 1'b0;
      busy       = 1'b0;
      bv_prev    = 1'b0;
    end else begin
      if (clear_eval) begin
        n_clr++;
        eval_valid = 1'b0;
        busy       = 1'b0;
      end
      if (board_valid && !bv_prev) begin
        n_rise++;
        last_low_run = low_run;
        busy = 1'b1;
        cnt  = 0;
      end else if (busy && !eval_valid && !ev_never) begin
        cnt++;
        if (cnt == ev_lat) begin
          eval_valid = 1'b1;
          eval_mg    = ev_mg;
          eval_eg    = ev_eg;
        end
      end
      low_run = board_valid ? 0 : low_run + 1;
      bv_prev = board_valid;
    end
  end

  task automatic wait_ready(input string tag);
    int t = 0;
    while (!req_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk({tag, "_rdy"}, req_ready, 1);
  endtask

  task automatic run_req(input string tag, input logic [BW-1:0] b, input logic w,
                         input logic [PS:0] ph, input int mg, input int eg,
                         input int exp_score, input logic exp_err,
                         input int exp_clr, input int exp_res);
    int acc, clr_c, res_c, t, clr0;
    ev_mg = EW'(mg);
    ev_eg = EW'(eg);
    wait_ready(tag);
    clr0 = n_clr;
    req_valid = 1'b1;
    req_board = b;
    req_white_to_move = w;
    req_phase = ph;
    @(negedge clk);
    req_valid = 1'b0;
    acc = cyc;
    chk({tag, "_rdy_drop"}, req_ready, 0);
    @(negedge clk);
    chk({tag, "_issue"}, {board_valid, white_to_move, board == b}, {1'b1, w, 1'b1});
    clr_c = -1;
    t = 0;
    while (!result_valid && t < 200) begin
      if (clear_eval && clr_c < 0) clr_c = cyc;
      @(negedge clk);
      t++;
    end
    if (clear_eval && clr_c < 0) clr_c = cyc;
    res_c = cyc;
    chk({tag, "_valid"}, result_valid, 1);
    chk({tag, "_score"}, result_score, exp_score);
    chk({tag, "_err"}, result_error, exp_err);
    chk({tag, "_clr_lat"}, clr_c - acc, exp_clr);
    chk({tag, "_res_lat"}, res_c - acc, exp_res);
    @(negedge clk);
    chk({tag, "_nclr"}, n_clr - clr0, 1);
    if (result_ready)
      chk({tag, "_release"}, {result_valid, req_ready}, 2'b01);
  endtask

  logic [BW-1:0] b1, b2;
  logic stable;
  int rise0;

  initial begin
    reset_n = 1'b0;
    req_valid = 1'b0;
    req_board = '0;
    req_white_to_move = 1'b0;
    req_phase = '0;
    eval_valid = 1'b0;
    eval_mg = '0;
    eval_eg = '0;
    result_ready = 1'b1;
    b1 = {32'h00FF_0000, 32'h1234_5678, 32'hDEAD_BEEF, 32'h0000_FF00};
    b2 = {32'h0F0F_0000, 32'h8765_4321, 32'hCAFE_F00D, 32'h00F0_0F00};

    @(negedge clk);
    chk("rst_outs", {req_ready, board_valid, clear_eval, result_valid, result_error,
                     white_to_move, |board, |result_score}, 0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("flush_pulse", {clear_eval, req_ready}, 2'b10);
    @(negedge clk);
    chk("flush_done", {clear_eval, req_ready}, 2'b01);

    run_req("p32",  b1, 1'b1, 6'd32, 100, -40, 100, 1'b0, 9, 11);
    run_req("p0",   b2, 1'b0, 6'd0,  100, -40, -40, 1'b0, 9, 11);
    run_req("p16",  b1, 1'b0, 6'd16, 100, -40, 30,  1'b0, 9, 11);
    run_req("p40",  b2, 1'b1, 6'd40, 100, -40, 100, 1'b0, 9, 11);
    run_req("flr_n", b1, 1'b1, 6'd16, -1, 0, -1, 1'b0, 9, 11);
    run_req("flr_p", b1, 1'b1, 6'd16, 1, 0, 0, 1'b0, 9, 11);
    run_req("mix7", b2, 1'b0, 6'd7, -1000, 500, 171, 1'b0, 9, 11);
    run_req("neg5", b1, 1'b1, 6'd5, -37, -11, -16, 1'b0, 9, 11);
    run_req("max32", b2, 1'b0, 6'd32, 8388607, -8388608, 8388607, 1'b0, 9, 11);
    run_req("min0", b2, 1'b1, 6'd0, 8388607, -8388608, -8388608, 1'b0, 9, 11);
    run_req("ext1", b1, 1'b0, 6'd1, 8388607, -8388608, -7864321, 1'b0, 9, 11);

    rise0 = n_rise;
    run_req("b2b_a", b1, 1'b1, 6'd24, 200, 40, 160, 1'b0, 9, 11);
    run_req("b2b_b", b2, 1'b0, 6'd8, -200, -40, -80, 1'b0, 9, 11);
    chk("b2b_rises", n_rise - rise0, 2);
    chk("b2b_gap", last_low_run >= 2, 1);

    ev_never = 1'b1;
    run_req("tmo", b1, 1'b1, 6'd20, 55, 66, 0, 1'b1, 65, 65);
    ev_never = 1'b0;
    run_req("post_tmo", b2, 1'b1, 6'd20, 64, 32, 52, 1'b0, 9, 11);

    result_ready = 1'b0;
    run_req("bp", b1, 1'b0, 6'd12, 320, -160, 20, 1'b0, 9, 11);
    stable = 1'b1;
    repeat (9) begin
      @(negedge clk);
      if (!(result_valid && result_score == 20 && !req_ready && !result_error)) stable = 1'b0;
    end
    chk("bp_hold", stable, 1);
    result_ready = 1'b1;
    @(negedge clk);
    chk("bp_release", {result_valid, req_ready}, 2'b01);

    ev_never = 1'b1;
    wait_ready("rst_mid");
    req_valid = 1'b1;
    req_board = b2;
    req_white_to_move = 1'b1;
    req_phase = 6'd10;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst_mid_wait", board_valid, 1);
    reset_n = 1'b0;
    #1;
    chk("rst_mid_outs", {req_ready, board_valid, clear_eval, result_valid, result_error,
                         white_to_move, |board, |result_score}, 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("rst_mid_flush", {clear_eval, req_ready, result_valid}, 3'b100);
    @(negedge clk);
    chk("rst_mid_idle", {clear_eval, req_ready, result_valid}, 3'b010);
    ev_never = 1'b0;
    run_req("recover", b1, 1'b1, 6'd32, -77, 9, -77, 1'b0, 9, 11);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/pawn_eval_sequencer.md
Name: pawn_eval_sequencer

Overview:
- Initiator side of the board-evaluation handshake: board_valid / board / white_to_move / clear_eval out, eval_mg / eval_eg / eval_valid in.
- Accepts one board request at a time from the search controller and presents it to a pawn evaluator.
- Waits for the result, releases the evaluator with clear_eval, then tapers mg/eg by game phase into one signed score.
- Returns the score over a valid/ready handshake. Includes a timeout guard and a post-reset flush of the evaluator.

Parameters:
- EVAL_WIDTH, 24, signed width of eval_mg, eval_eg and result_score.
- PHASE_SHIFT, 5, log2 of full game phase; legal phase is 0..2^PHASE_SHIFT (32 = pure middlegame).
- TIMEOUT, 64, maximum cycles spent in WAIT before the request is aborted.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  sequencer idle, request accepted when req_valid&&req_ready
- req_board  in  `BOARD_WIDTH  board to evaluate
- req_white_to_move  in  1  side to move
- req_phase  in  PHASE_SHIFT+1  game phase
- board_valid  out  1  to evaluator; rising edge starts an evaluation
- board  out  `BOARD_WIDTH  to evaluator
- white_to_move  out  1  to evaluator
- clear_eval  out  1  one-cycle release pulse to evaluator
- eval_mg  in  EVAL_WIDTH  signed middlegame result
- eval_eg  in  EVAL_WIDTH  signed endgame result
- eval_valid  in  1  evaluator result ready (level)
- result_valid  out  1  score available
- result_ready  in  1  consumer accepts score
- result_score  out  EVAL_WIDTH  signed tapered score
- result_error  out  1  qualifies result_valid: evaluation timed out

Behaviour:
- Reset (async, reset_n=0): state=FLUSH.
- Reset values: req_ready, board_valid, clear_eval, result_valid, result_error, result_score, board, white_to_move all 0.
- Reset mid-operation aborts silently; no result is produced.
- FLUSH: clear_eval=1 for exactly one cycle, frees an evaluator parked awaiting clear. Then go to IDLE.
- IDLE:
  - req_ready=1, board_valid=0, eval_valid ignored.
  - On req_valid: latch board, white_to_move, and phase. Phase is clamped to 2^PHASE_SHIFT if larger.
  - Drop req_ready, go to ISSUE.
- ISSUE: board_valid<=1, timer<=0, go to WAIT.
- board, white_to_move and board_valid are held stable from ISSUE until the clear_eval cycle.
- WAIT: timer++ each cycle.
  - If eval_valid: register eval_mg and eval_eg, pulse clear_eval for one cycle, board_valid<=0, go to MULT.
  - Else if timer==TIMEOUT-1: pulse clear_eval, board_valid<=0, result_score<=0, result_error<=1, result_valid<=1, go to DONE.
  - eval_valid takes priority if both occur in the same cycle.
- MULT: register pm=mg*phase and pe=eg*((1<<PHASE_SHIFT)-phase). Products are signed, EVAL_WIDTH+PHASE_SHIFT+2 bits.
- SUM:
  - result_score <= (pm+pe) >>> PHASE_SHIFT. Arithmetic shift, floor toward -inf.
  - The result is a convex combination, so truncation to EVAL_WIDTH never overflows and no saturation is needed.
  - result_error<=0, result_valid<=1, go to DONE.
- DONE: result_valid and result_score are held stable until result_ready=1. On that cycle clear result_valid and result_error and go to IDLE.
- board_valid is low for at least 2 cycles between evaluations (MULT onward). Every issue is therefore a clean rising edge.
- Latency: accept at cycle 0.
  - board_valid rises at cycle 1.
  - If eval_valid is first seen at cycle k, clear_eval is at k+1 and result_valid rises at k+3.
- No request pipelining: one outstanding request, strict in-order.

Test Plan:
- Reset release: clear_eval=1 in the first clock after reset_n rises, 0 thereafter. req_ready=1 from the following cycle.
- Basic taper, eval_mg=100, eval_eg=-40:
  - phase 32 -> score 100.
  - phase 0 -> score -40.
  - phase 16 -> score 30.
  - phase 40 (clamped to 32) -> score 100.
  - result_error=0 in every case.
- Floor rounding: mg=-1, eg=0, phase 16 -> score -1. mg=1, eg=0, phase 16 -> score 0.
- Back-to-back with a behavioural evaluator of 7-cycle latency:
  - Two requests with result_ready tied high.
  - Two distinct board_valid rising edges separated by at least 2 low cycles.
  - Exactly one clear_eval pulse per request; results in order.
- Timeout: evaluator never asserts eval_valid.
  - clear_eval pulses after 64 WAIT cycles.
  - result_valid=1, result_error=1, score 0.
  - The next request proceeds normally.
- Backpressure and reset: hold result_ready=0 for 10 cycles -> result stable, req_ready=0. Assert reset_n=0 mid-WAIT -> all outputs 0 immediately, FLUSH pulse after release.
